// File: rtl/hazard_scoreboard_unit.sv
// Hazard controller for the 5-stage core. It handles forwarding, load-use bubbles, mispredict flushes,
// multi-cycle execute stalls and data-memory waits, and keeps a saturating count of stall cycles.
//   state   | meaning
//   MC_IDLE | no multi-cycle op active; MC_Start_E launches one
//   MC_BUSY | multi-cycle op executing; mc_cnt counts down to the last stall cycle
//   MC_DONE | result ready; waits for the M-stage memory access before returning to idle
module hazard_scoreboard_unit #(
  parameter int REG_ADDR_W = 5,
  parameter int MC_LATENCY = 4,
  parameter int CNT_W      = 32
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [REG_ADDR_W-1:0] RS1_D,
  input  logic [REG_ADDR_W-1:0] RS2_D,
  input  logic [REG_ADDR_W-1:0] RS1_E,
  input  logic [REG_ADDR_W-1:0] RS2_E,
  input  logic [REG_ADDR_W-1:0] RD_E,
  input  logic [REG_ADDR_W-1:0] RD_M,
  input  logic [REG_ADDR_W-1:0] RD_W,
  input  logic [1:0]            Result_Src_Sel_E,
  input  logic                  REG_W_En_M,
  input  logic                  REG_W_En_W,
  input  logic                  Branch_Taken_E,
  input  logic                  Predict_Taken_E,
  input  logic                  MC_Start_E,
  input  logic                  Mem_Ready_M,
  input  logic                  Stall_Count_Clr,
  output logic [1:0]            FWD_SrcA,
  output logic [1:0]            FWD_SrcB,
  output logic                  PC_En,
  output logic                  Stall_D,
  output logic                  Stall_E,
  output logic                  Stall_M,
  output logic                  Flush_D,
  output logic                  Flush_E,
  output logic                  Flush_M,
  output logic                  Flush_W,
  output logic                  MC_Busy,
  output logic                  MC_Done,
  output logic [CNT_W-1:0]      Stall_Count
);

  localparam logic [1:0] FWD_NONE   = 2'b00;
  localparam logic [1:0] FWD_MEM    = 2'b01;
  localparam logic [1:0] FWD_WB     = 2'b10;
  localparam logic [1:0] RESULT_MEM = 2'b01;

  localparam int MC_CW = (MC_LATENCY > 1) ? $clog2(MC_LATENCY) : 1;
  localparam logic [MC_CW-1:0] MC_LOAD = MC_CW'(MC_LATENCY - 1);

  typedef enum logic [1:0] {MC_IDLE, MC_BUSY, MC_DONE} mc_state_t;

  mc_state_t        mc_state, mc_state_nxt;
  logic [MC_CW-1:0] mc_cnt, mc_cnt_nxt;
  logic [CNT_W-1:0] stall_cnt;
  logic             mc_stall, load_use, mispredict;

  function automatic logic [1:0] fwd_sel(input logic [REG_ADDR_W-1:0] rs);
    if (rs == '0)                     return FWD_NONE;
    else if (REG_W_En_M && RD_M == rs) return FWD_MEM;
    else if (REG_W_En_W && RD_W == rs) return FWD_WB;
    else                               return FWD_NONE;
  endfunction

  always_comb begin
    mc_state_nxt = mc_state;
    mc_cnt_nxt   = mc_cnt;
    unique case (mc_state)
      MC_IDLE: if (MC_Start_E) begin
        mc_cnt_nxt   = MC_LOAD;
        mc_state_nxt = (MC_LATENCY == 1) ? MC_DONE : MC_BUSY;
      end
      MC_BUSY: begin
        mc_cnt_nxt = mc_cnt - 1'b1;
        if (mc_cnt == MC_CW'(1)) mc_state_nxt = MC_DONE;
      end
      MC_DONE: if (Mem_Ready_M) mc_state_nxt = MC_IDLE;
      default: mc_state_nxt = MC_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      mc_state  <= MC_IDLE;
      mc_cnt    <= '0;
      stall_cnt <= '0;
    end else begin
      mc_state <= mc_state_nxt;
      mc_cnt   <= mc_cnt_nxt;
      if (Stall_Count_Clr)                  stall_cnt <= '0;
      else if (!PC_En && stall_cnt != '1)   stall_cnt <= stall_cnt + 1'b1;
    end
  end

  assign mc_stall   = (mc_state == MC_IDLE && MC_Start_E) || mc_state == MC_BUSY;
  assign load_use   = Result_Src_Sel_E == RESULT_MEM && RD_E != '0 && (RD_E == RS1_D || RD_E == RS2_D);
  assign mispredict = Branch_Taken_E != Predict_Taken_E;
  assign Stall_Count = stall_cnt;

  // One pipeline action per cycle; reset overrides everything with a full flush.
  always_comb begin
    FWD_SrcA = fwd_sel(RS1_E);
    FWD_SrcB = fwd_sel(RS2_E);
    PC_En    = 1'b1;
    Stall_D  = 1'b0;
    Stall_E  = 1'b0;
    Stall_M  = 1'b0;
    Flush_D  = 1'b0;
    Flush_E  = 1'b0;
    Flush_M  = 1'b0;
    Flush_W  = 1'b0;
    MC_Busy  = !RST && mc_state == MC_BUSY;
    MC_Done  = !RST && mc_state == MC_DONE;
    if (RST) begin
      FWD_SrcA = FWD_NONE;
      FWD_SrcB = FWD_NONE;
      PC_En    = 1'b0;
      Flush_D  = 1'b1;
      Flush_E  = 1'b1;
      Flush_M  = 1'b1;
      Flush_W  = 1'b1;
    end else if (!Mem_Ready_M) begin
      PC_En   = 1'b0;
      Stall_D = 1'b1;
      Stall_E = 1'b1;
      Stall_M = 1'b1;
      Flush_W = 1'b1;
    end else if (mc_stall) begin
      PC_En   = 1'b0;
      Stall_D = 1'b1;
      Stall_E = 1'b1;
      Flush_M = 1'b1;
    end else if (mispredict) begin
      Flush_D = 1'b1;
      Flush_E = 1'b1;
    end else if (load_use) begin
      PC_En   = 1'b0;
      Stall_D = 1'b1;
      Flush_E = 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Directed bench for hazard_scoreboard_unit: a default instance (MC_LATENCY=4, CNT_W=32) and a
// short-latency, narrow-counter instance (MC_LATENCY=1, CNT_W=4) driven by the same inputs.
module tb_hazard_scoreboard_unit;
  localparam logic [1:0] FWD_NONE = 2'b00, FWD_MEM = 2'b01, FWD_WB = 2'b10;
  localparam logic [1:0] RESULT_ALU = 2'b00, RESULT_MEM = 2'b01;
  // {PC_En, Stall_D, Stall_E, Stall_M, Flush_D, Flush_E, Flush_M, Flush_W}
  localparam logic [7:0] C_RST = 8'h0F, C_RUN = 8'h80, C_MEMW = 8'h71;
  localparam logic [7:0] C_MC = 8'h62, C_MISP = 8'h8C, C_LU = 8'h44;

  logic       CLK = 1'b0;
  logic       RST;
  logic [4:0] RS1_D, RS2_D, RS1_E, RS2_E, RD_E, RD_M, RD_W;
  logic [1:0] Result_Src_Sel_E;
  logic       REG_W_En_M, REG_W_En_W, Branch_Taken_E, Predict_Taken_E;
  logic       MC_Start_E, Mem_Ready_M, Stall_Count_Clr;

  logic [1:0]  fwd_a, fwd_b, fwd_a1, fwd_b1;
  logic        pc_en, st_d, st_e, st_m, fl_d, fl_e, fl_m, fl_w, busy, done;
  logic        pc_en1, st_d1, st_e1, st_m1, fl_d1, fl_e1, fl_m1, fl_w1, busy1, done1;
  logic [31:0] cnt;
  logic [3:0]  cnt1;
  logic [7:0]  ctrl, ctrl1;

  int checks = 0;
  int failures = 0;

  assign ctrl  = {pc_en, st_d, st_e, st_m, fl_d, fl_e, fl_m, fl_w};
  assign ctrl1 = {pc_en1, st_d1, st_e1, st_m1, fl_d1, fl_e1, fl_m1, fl_w1};

  hazard_scoreboard_unit dut (
    .CLK(CLK), .RST(RST), .RS1_D(RS1_D), .RS2_D(RS2_D), .RS1_E(RS1_E), .RS2_E(RS2_E),
    .RD_E(RD_E), .RD_M(RD_M), .RD_W(RD_W), .Result_Src_Sel_E(Result_Src_Sel_E),
    .REG_W_En_M(REG_W_En_M), .REG_W_En_W(REG_W_En_W), .Branch_Taken_E(Branch_Taken_E),
    .Predict_Taken_E(Predict_Taken_E), .MC_Start_E(MC_Start_E), .Mem_Ready_M(Mem_Ready_M),
    .Stall_Count_Clr(Stall_Count_Clr), .FWD_SrcA(fwd_a), .FWD_SrcB(fwd_b), .PC_En(pc_en),
    .Stall_D(st_d), .Stall_E(st_e), .Stall_M(st_m), .Flush_D(fl_d), .Flush_E(fl_e),
    .Flush_M(fl_m), .Flush_W(fl_w), .MC_Busy(busy), .MC_Done(done), .Stall_Count(cnt)
  );

  hazard_scoreboard_unit #(.MC_LATENCY(1), .CNT_W(4)) dut1 (
    .CLK(CLK), .RST(RST), .RS1_D(RS1_D), .RS2_D(RS2_D), .RS1_E(RS1_E), .RS2_E(RS2_E),
    .RD_E(RD_E), .RD_M(RD_M), .RD_W(RD_W), .Result_Src_Sel_E(Result_Src_Sel_E),
    .REG_W_En_M(REG_W_En_M), .REG_W_En_W(REG_W_En_W), .Branch_Taken_E(Branch_Taken_E),
    .Predict_Taken_E(Predict_Taken_E), .MC_Start_E(MC_Start_E), .Mem_Ready_M(Mem_Ready_M),
    .Stall_Count_Clr(Stall_Count_Clr), .FWD_SrcA(fwd_a1), .FWD_SrcB(fwd_b1), .PC_En(pc_en1),
    .Stall_D(st_d1), .Stall_E(st_e1), .Stall_M(st_m1), .Flush_D(fl_d1), .Flush_E(fl_e1),
    .Flush_M(fl_m1), .Flush_W(fl_w1), .MC_Busy(busy1), .MC_Done(done1), .Stall_Count(cnt1)
  );

  initial forever #5 CLK = ~CLK;

  initial begin
    #100000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic defaults();
    RS1_D = '0; RS2_D = '0; RS1_E = '0; RS2_E = '0;
    RD_E = '0; RD_M = '0; RD_W = '0;
    Result_Src_Sel_E = RESULT_ALU;
    REG_W_En_M = 1'b0; REG_W_En_W = 1'b0;
    Branch_Taken_E = 1'b0; Predict_Taken_E = 1'b0;
    MC_Start_E = 1'b0; Mem_Ready_M = 1'b1; Stall_Count_Clr = 1'b0;
  endtask

  initial begin
    defaults();
    RST = 1'b1;

    // reset: outputs forced even with a forwarding match present
    @(negedge CLK); RS1_E = 5'd1; RD_M = 5'd1; REG_W_En_M = 1'b1; #1;
    chk("rst_ctrl", ctrl, C_RST);
    chk("rst_fwd_a", fwd_a, FWD_NONE);
    chk("rst_busy_done", {busy, done}, 2'b00);
    chk("rst_cnt", cnt, 0);

    // forwarding: MEM beats WB, x0 never forwarded
    @(negedge CLK); RST = 1'b0; RD_W = 5'd1; REG_W_En_W = 1'b1; RS2_E = 5'd0; #1;
    chk("fwd_a_mem_over_wb", fwd_a, FWD_MEM);
    chk("fwd_b_x0_none", fwd_b, FWD_NONE);
    chk("run_ctrl", ctrl, C_RUN);
    chk("run_cnt0", cnt, 0);
    @(negedge CLK); REG_W_En_M = 1'b0; RS2_E = 5'd1; #1;
    chk("fwd_a_wb", fwd_a, FWD_WB);
    chk("fwd_b_wb", fwd_b, FWD_WB);
    @(negedge CLK); RS1_E = 5'd0; RS2_E = 5'd3; RD_M = 5'd3; REG_W_En_M = 1'b1; RD_W = 5'd0; #1;
    chk("fwd_a_rs0_rd0", fwd_a, FWD_NONE);
    chk("fwd_b_mem", fwd_b, FWD_MEM);

    // load-use, then load-use plus mispredict, then load into x0
    @(negedge CLK); defaults(); Result_Src_Sel_E = RESULT_MEM; RD_E = 5'd5; RS2_D = 5'd5; #1;
    chk("load_use_ctrl", ctrl, C_LU);
    @(negedge CLK); defaults(); #1;
    chk("after_lu_ctrl", ctrl, C_RUN);
    chk("after_lu_cnt", cnt, 1);
    @(negedge CLK); Result_Src_Sel_E = RESULT_MEM; RD_E = 5'd5; RS2_D = 5'd5; Branch_Taken_E = 1'b1; #1;
    chk("misp_over_lu_ctrl", ctrl, C_MISP);
    @(negedge CLK); defaults(); Result_Src_Sel_E = RESULT_MEM; RD_E = 5'd0; #1;
    chk("load_x0_ctrl", ctrl, C_RUN);
    chk("load_x0_cnt", cnt, 1);

    // multi-cycle op, latency 4; cycle 3 also carries a mispredict and a load-use
    for (int c = 1; c <= 5; c++) begin
      @(negedge CLK); defaults(); MC_Start_E = 1'b1;
      if (c == 3) begin
        Branch_Taken_E = 1'b1; Result_Src_Sel_E = RESULT_MEM; RD_E = 5'd7; RS1_D = 5'd7;
      end
      #1;
      chk($sformatf("mc_ctrl_%0d", c), ctrl, (c <= 4) ? C_MC : C_RUN);
      chk($sformatf("mc_busy_%0d", c), busy, (c >= 2 && c <= 4));
      chk($sformatf("mc_done_%0d", c), done, (c == 5));
    end
    @(negedge CLK); defaults(); #1;
    chk("mc_after_done", done, 1'b0);
    chk("mc_after_cnt", cnt, 5);

    // memory wait over BUSY cycles 3-4 and the first DONE cycle
    for (int c = 1; c <= 6; c++) begin
      @(negedge CLK); defaults(); MC_Start_E = 1'b1; Mem_Ready_M = !(c >= 3 && c <= 5); #1;
      chk($sformatf("mw_ctrl_%0d", c), ctrl, (c <= 2) ? C_MC : (c <= 5) ? C_MEMW : C_RUN);
      chk($sformatf("mw_busy_%0d", c), busy, (c >= 2 && c <= 4));
      chk($sformatf("mw_done_%0d", c), done, (c >= 5));
    end
    @(negedge CLK); defaults(); #1;
    chk("mw_after_done", done, 1'b0);
    chk("mw_after_ctrl", ctrl, C_RUN);
    chk("mw_after_cnt", cnt, 10);

    // clear wins over increment
    @(negedge CLK); Mem_Ready_M = 1'b0; Stall_Count_Clr = 1'b1; #1;
    chk("clr_ctrl", ctrl, C_MEMW);
    @(negedge CLK); defaults(); #1;
    chk("clr_cnt", cnt, 0);

    // reset during BUSY cycle 2
    @(negedge CLK); MC_Start_E = 1'b1; #1;
    chk("rmid_c1_ctrl", ctrl, C_MC);
    @(negedge CLK); #1;
    chk("rmid_c2_busy", busy, 1'b1);
    RST = 1'b1; #1;
    chk("rmid_forced_busy", busy, 1'b0);
    chk("rmid_forced_ctrl", ctrl, C_RST);
    @(negedge CLK); RST = 1'b0; MC_Start_E = 1'b0; #1;
    chk("rmid_after_busy", busy, 1'b0);
    chk("rmid_after_ctrl", ctrl, C_RUN);
    chk("rmid_after_cnt", cnt, 0);

    // MC_LATENCY=1 instance: one stall cycle then DONE
    @(negedge CLK); RST = 1'b1; #1;
    @(negedge CLK); RST = 1'b0; MC_Start_E = 1'b1; #1;
    chk("l1_c1_ctrl", ctrl1, C_MC);
    chk("l1_c1_busy_done", {busy1, done1}, 2'b00);
    @(negedge CLK); #1;
    chk("l1_c2_ctrl", ctrl1, C_RUN);
    chk("l1_c2_busy_done", {busy1, done1}, 2'b01);
    @(negedge CLK); MC_Start_E = 1'b0; #1;
    chk("l1_c3_done", done1, 1'b0);
    chk("l1_c3_cnt", cnt1, 1);

    // 20 stall cycles: 4-bit counter saturates at 15, 32-bit reaches 20
    @(negedge CLK); RST = 1'b1; #1;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK); RST = 1'b0; Mem_Ready_M = 1'b0; #1;
      if (i == 14) chk("sat_cnt1_14", cnt1, 14);
    end
    @(negedge CLK); defaults(); #1;
    chk("sat_cnt1_15", cnt1, 15);
    chk("sat_cnt_20", cnt, 20);
    chk("sat_ctrl1", ctrl1, C_RUN);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
